diff_manchester_framer: RTL and testbench

Frame controller downstream of the differential-Manchester decoder. Consumes the decoded 1-bit-per-beat AXI-Stream, hunts for a sync word, reads a length byte, then packs the payload MSB-first into bytes and emits them as an AXI-Stream packet with `tlast` on the final byte. Drops malformed frames, reports them on status pulses, and re-hunts.

---
 rtl/diff_manchester_framer.sv | 177 +++++++++++++++++
 tb/tb_diff_manchester_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_manchester_framer.sv
// diff_manchester_framer: frames the decoded differential-Manchester bit stream.
// Hunts for SYNC_WORD, reads a length byte, then packs the payload MSB-first
// into bytes on an AXI-Stream master with tlast on the final byte.
// A length of zero or above MAX_LEN pulses len_err and returns to HUNT. An input
// tlast in the middle of a frame pulses frame_abort and returns to HUNT.
// Optional macro DIFF_FRAMER_STATS_EN enables the 16-bit wrapping frame_count.
// Without it, frame_count is tied to zero.
module diff_manchester_framer #(
  parameter int                   C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int                   C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int                   SYNC_BITS              = 16,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD              = 16'hD391,
  parameter int                   MAX_LEN                = 255
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  sync_lock,
  output logic                                  len_err,
  output logic                                  frame_abort,
  output logic [15:0]                           frame_count
);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

  state_t                            state;
  logic [SYNC_BITS-1:0]              sync_sr;
  logic [SYNC_BITS-1:0]              sync_next;
  logic [5:0]                        fill;
  logic [5:0]                        fill_next;
  logic [2:0]                        bit_cnt;
  logic [7:0]                        shift_sr;
  logic [7:0]                        shift_next;
  logic [7:0]                        remaining;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                              tvalid_q;
  logic                              tlast_q;
  logic                              len_err_q;
  logic                              abort_q;
  logic                              din;
  logic                              take;
  logic                              final_bit;
  logic                              frame_done;
  logic                              unused_in;

  assign din       = s00_axis_tdata[0];
  assign unused_in = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], s00_axis_tstrb};

  // Handshake qualification and next values of the shift registers.
  always_comb begin
    take       = s00_axis_tvalid && s00_axis_tready;
    sync_next  = (sync_sr << 1) | SYNC_BITS'(din);
    fill_next  = (fill < 6'(SYNC_BITS)) ? fill + 6'd1 : fill;
    shift_next = {shift_sr[6:0], din};
    final_bit  = (state == PAYLOAD) && (bit_cnt == 3'd7) && (remaining == 8'd1);
    frame_done = take && final_bit;
  end

  // Stall input only when a completed byte has nowhere to go.
  assign s00_axis_tready = !((state == PAYLOAD) && (bit_cnt == 3'd7) &&
                             tvalid_q && !m00_axis_tready);

  // Frame FSM with the single-entry output register and status pulses.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state     <= HUNT;
      sync_sr   <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      remaining <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
      if (tvalid_q && m00_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      // The sync hunter is idle outside HUNT; holding it clear there makes
      // every entry to HUNT start from an empty register and fill count.
      if (state != HUNT) begin
        sync_sr <= '0;
        fill    <= '0;
      end
      if (take) begin
        case (state)
          HUNT: begin
            sync_sr <= sync_next;
            fill    <= fill_next;
            if ((fill_next >= 6'(SYNC_BITS)) && (sync_next == SYNC_WORD)) begin
              state   <= LEN;
              bit_cnt <= '0;
            end
          end
          LEN: begin
            shift_sr <= shift_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (s00_axis_tlast) begin
              abort_q <= 1'b1;
              state   <= HUNT;
              bit_cnt <= '0;
            end else if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if ((shift_next == 8'd0) || (int'(shift_next) > MAX_LEN)) begin
                len_err_q <= 1'b1;
                state     <= HUNT;
              end else begin
                remaining <= shift_next;
                state     <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            shift_sr <= shift_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (s00_axis_tlast && !final_bit) begin
              abort_q <= 1'b1;
              state   <= HUNT;
              bit_cnt <= '0;
            end else if (bit_cnt == 3'd7) begin
              tdata_q   <= C_M00_AXIS_TDATA_WIDTH'(shift_next);
              tvalid_q  <= 1'b1;
              tlast_q   <= (remaining == 8'd1);
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                state <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = '1;
  assign sync_lock       = (state != HUNT);
  assign len_err         = len_err_q;
  assign frame_abort     = abort_q;

`ifdef DIFF_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q;

  // Wrapping count of completed frames.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  logic unused_done;
  assign unused_done = frame_done;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_diff_manchester_framer.sv
// Bench for diff_manchester_framer: drives framed bit streams and checks the
// output bytes against a queue of expected {tlast, byte} entries.
module tb_diff_manchester_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tstrb;
  logic        m_tvalid;
  logic        rdy;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;
  logic        sync_lock;
  logic        len_err;
  logic        frame_abort;
  logic [15:0] frame_count;

  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  logic [15:0] fc_exp;
  logic        done;

  always #5 clk = ~clk;

  diff_manchester_framer #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .SYNC_BITS(16),
    .SYNC_WORD(16'hD391),
    .MAX_LEN(16)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready),
    .s00_axis_tdata (s_tdata),
    .s00_axis_tlast (s_tlast),
    .s00_axis_tstrb (s_tstrb),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(rdy),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tlast (m_tlast),
    .m00_axis_tstrb (m_tstrb),
    .sync_lock      (sync_lock),
    .len_err        (len_err),
    .frame_abort    (frame_abort),
    .frame_count    (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output monitor: a beat transfers on the posedge following a negedge
  // where both tvalid and tready are high.
  always @(negedge clk) begin
    if (!rst && m_tvalid && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'b0, m_tdata[7:0]}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", m_tdata, {24'b0, mon_e[7:0]});
        check("beat_last", {31'b0, m_tlast}, {31'b0, mon_e[8]});
      end
    end
  end

  task automatic send_bit(input logic b, input logic l);
    int t;
    s_tdata    = '0;
    s_tdata[0] = b;
    s_tlast    = l;
    s_tvalid   = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      t++;
      if (t > 500) begin
        check("in_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Send the n low bits of v, MSB first; tlast on bit position last_at.
  task automatic send_word(input logic [31:0] v, input int n, input int last_at);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i], (n - 1 - i) == last_at);
    end
  endtask

  task automatic count_frame;
`ifdef DIFF_FRAMER_STATS_EN
    fc_exp = fc_exp + 16'd1;
`endif
  endtask

  // Payload bytes are taken left-justified from bytes (first byte in [23:16]).
  task automatic send_payload(input int n, input logic [23:0] bytes);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(bytes >> (16 - 8 * i));
      exp_q.push_back({(i == n - 1), b});
      send_word({24'b0, b}, 8, -1);
    end
    count_frame();
  endtask

  task automatic send_frame(input int n, input logic [23:0] bytes);
    send_word(32'hD391, 16, -1);
    send_word(32'(n), 8, -1);
    send_payload(n, bytes);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    check(tag, exp_q.size(), 32'd0);
    check({tag, "_fc"}, {16'b0, frame_count}, {16'b0, fc_exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = '0;
    rdy = 1'b1; fc_exp = '0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", {31'b0, m_tlast}, 32'd0);
    check("rst_lock", {31'b0, sync_lock}, 32'd0);
    check("rst_len_err", {31'b0, len_err}, 32'd0);
    check("rst_abort", {31'b0, frame_abort}, 32'd0);
    check("rst_fc", {16'b0, frame_count}, 32'd0);
    check("tstrb", {28'b0, m_tstrb}, 32'hF);
    rst = 1'b0;

    // Good frame with sync_lock timing
    send_word(32'h69C8, 15, -1);
    check("lock_before_sync", {31'b0, sync_lock}, 32'd0);
    send_bit(1'b1, 1'b0);
    check("lock_after_sync", {31'b0, sync_lock}, 32'd1);
    check("tready_hunt", {31'b0, s_tready}, 32'd1);
    send_word(32'h02, 8, -1);
    send_payload(2, 24'hA53C00);
    check("lock_after_frame", {31'b0, sync_lock}, 32'd0);
    wait_drain("good");

    // Length rejects
    send_word(32'hD391, 16, -1);
    send_word(32'h00, 8, -1);
    check("len0_pulse", {31'b0, len_err}, 32'd1);
    check("len0_lock", {31'b0, sync_lock}, 32'd0);
    @(posedge clk); #1;
    check("len0_pulse_end", {31'b0, len_err}, 32'd0);
    send_word(32'hD391, 16, -1);
    send_word(32'h11, 8, -1);
    check("len17_pulse", {31'b0, len_err}, 32'd1);
    @(posedge clk); #1;
    check("len17_pulse_end", {31'b0, len_err}, 32'd0);
    send_frame(1, 24'h7E0000);
    wait_drain("after_len");

    // Backpressure: 3 bytes with the output stalled
    rdy = 1'b0;
    done = 1'b0;
    fork
      begin
        send_frame(3, 24'hA1B2C3);
        done = 1'b1;
      end
    join_none
    repeat (60) @(posedge clk);
    #1;
    check("stall_tready", {31'b0, s_tready}, 32'd0);
    check("stall_tvalid", {31'b0, m_tvalid}, 32'd1);
    check("stall_tdata", m_tdata, 32'h0000_00A1);
    check("stall_tlast", {31'b0, m_tlast}, 32'd0);
    rdy = 1'b1;
    for (int i = 0; i < 300 && !done; i++) @(posedge clk);
    check("stall_done", {31'b0, done}, 32'd1);
    wait_drain("stall");

    // Sync discrimination and HUNT re-entry clearing
    send_word(32'hFFFF, 16, -1);
    send_word(32'hD390, 16, -1);
    check("nolock_d390", {31'b0, sync_lock}, 32'd0);
    send_word(32'hD391, 16, -1);
    check("lock_d391", {31'b0, sync_lock}, 32'd1);
    send_word(32'hD3, 8, -1);
    check("lenD3_pulse", {31'b0, len_err}, 32'd1);
    send_word(32'h91, 8, -1);
    check("straddle_nolock", {31'b0, sync_lock}, 32'd0);
    send_word(32'hD391, 16, -1);
    check("relock", {31'b0, sync_lock}, 32'd1);
    send_word(32'h01, 8, -1);
    send_payload(1, 24'h5A0000);
    wait_drain("sync");

    // Abort on bit 3 of the first payload byte
    send_word(32'hD391, 16, -1);
    send_word(32'h02, 8, -1);
    send_word(32'hA, 4, 3);
    check("abort_pulse", {31'b0, frame_abort}, 32'd1);
    check("abort_lock", {31'b0, sync_lock}, 32'd0);
    @(posedge clk); #1;
    check("abort_pulse_end", {31'b0, frame_abort}, 32'd0);
    check("abort_no_beat", {31'b0, m_tvalid}, 32'd0);
    send_frame(2, 24'h1234_00);
    wait_drain("after_abort");

    // Reset while a byte is held in the output register
    rdy = 1'b0;
    send_word(32'hD391, 16, -1);
    send_word(32'h02, 8, -1);
    send_word(32'h55, 8, -1);
    check("pre_rst_tvalid", {31'b0, m_tvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("mid_rst_tdata", m_tdata, 32'd0);
    check("mid_rst_tlast", {31'b0, m_tlast}, 32'd0);
    check("mid_rst_lock", {31'b0, sync_lock}, 32'd0);
    check("mid_rst_fc", {16'b0, frame_count}, 32'd0);
    @(posedge clk); #1;
    rdy = 1'b1;
    fc_exp = '0;
    rst = 1'b0;
    send_frame(2, 24'hC0DE00);
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
